// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the multi-channel DDS scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sine_sched_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_PHASE_W = 16;
    localparam int DEF_LUT_LAT = 1;

    // Width of a channel id; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_acc_bank.sv
// Per-channel FTW / enable / phase-accumulator register file with channel finders.
// Latency: writes and accumulate land on the next clk edge; finder outputs are combinational.
// Backpressure: none; caller guarantees write and accumulate never target a sweep in progress.
//
// Ports:
//   wr_en/wr_ch/wr_ftw/wr_chen : config write port (cfg_en=0 also zeroes the accumulator)
//   adv/ptr                    : accumulate port, acc[ptr] += ftw[ptr] when adv
//   any_en/first_ch/first_phase: lowest enabled channel and its phase (post-write view)
//   next_vld/next_ch/next_phase: lowest enabled channel strictly above ptr and its phase
module phase_acc_bank
    import sine_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int CH_W    = ch_width(DEF_NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [PHASE_W-1:0] wr_ftw,
    input  logic               wr_chen,
    input  logic               adv,
    input  logic [CH_W-1:0]    ptr,
    output logic               any_en,
    output logic [CH_W-1:0]    first_ch,
    output logic [7:0]         first_phase,
    output logic               next_vld,
    output logic [CH_W-1:0]    next_ch,
    output logic [7:0]         next_phase
);

    logic [PHASE_W-1:0] acc [NUM_CH];
    logic [PHASE_W-1:0] ftw [NUM_CH];
    logic [NUM_CH-1:0]  en;
    logic [NUM_CH-1:0]  en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                ftw[i] <= '0;
            end
            en <= '0;
        end else begin
            if (adv) begin
                acc[ptr] <= acc[ptr] + ftw[ptr];
            end
            if (wr_en) begin
                ftw[wr_ch] <= wr_ftw;
                en[wr_ch]  <= wr_chen;
                // Disabling a channel restarts its phase from zero when re-enabled.
                if (!wr_chen) begin
                    acc[wr_ch] <= '0;
                end
            end
        end
    end

    // Enable vector as it will be after a write in this cycle, so a tick that
    // coincides with a config write already sees the new channel set.
    always_comb begin
        en_nxt = en;
        if (wr_en) begin
            en_nxt[wr_ch] = wr_chen;
        end
    end

    // Descending scan: the last hit is the lowest index.
    always_comb begin
        any_en   = |en_nxt;
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en_nxt[i]) begin
                first_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        next_vld = 1'b0;
        next_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en_nxt[i] && (i > int'(ptr))) begin
                next_vld = 1'b1;
                next_ch  = CH_W'(i);
            end
        end
    end

    // A disabled channel always holds acc=0, so reading the registered acc of a
    // channel enabled in this very cycle already gives its correct start phase.
    assign first_phase = acc[first_ch][PHASE_W-1 -: 8];
    assign next_phase  = acc[next_ch][PHASE_W-1 -: 8];

endmodule

// File: rtl/sine_channel_scheduler.sv
// Time-multiplexes one sine LUT over NUM_CH DDS channels, one enabled channel per cycle per tick.
// Latency: tick -> first lut_phase 1 cycle; tick -> first out_valid LUT_LAT+2 cycles.
// Backpressure: cfg_ready low while a sweep runs; ticks during a sweep are dropped and flagged in overrun.
//
// Ports:
//   tick                       : sample-rate strobe starting a sweep
//   cfg_valid/cfg_ready/...    : channel config write (ftw, enable)
//   ovr_clr                    : clears the sticky overrun flag
//   lut_phase/lut_sample       : interface to the shared sine_lookup
//   out_valid/out_ch/out_sample: tagged LUT results, one cycle each
//   busy/overrun               : sweep status
module sine_channel_scheduler
    import sine_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_LAT = DEF_LUT_LAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PHASE_W-1:0]        cfg_ftw,
    input  logic                      cfg_en,
    input  logic                      ovr_clr,
    output logic [7:0]                lut_phase,
    input  logic [7:0]                lut_sample,
    output logic                      out_valid,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic [7:0]                out_sample,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CH_W = ch_width(NUM_CH);

    sched_state_t    state;
    sched_state_t    state_nxt;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ptr_nxt;
    logic            issue;
    logic            load_phase;
    logic            phase_from_first;
    logic            cfg_fire;
    logic            cfg_rdy_q;

    logic            any_en;
    logic [CH_W-1:0] first_ch;
    logic [7:0]      first_phase;
    logic            next_vld;
    logic [CH_W-1:0] next_ch;
    logic [7:0]      next_phase;

    // Issue tracking: bit 0 is the newest issue, bit LUT_LAT-1 lines up with lut_sample.
    logic [LUT_LAT-1:0] pipe_vld;
    logic [CH_W-1:0]    pipe_ch [LUT_LAT];
    logic [LUT_LAT-1:0] pipe_after;
    logic               drain_done;

    assign busy      = (state != IDLE);
    assign cfg_ready = cfg_rdy_q;
    assign cfg_fire  = cfg_valid & cfg_rdy_q;

    phase_acc_bank #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .CH_W    (CH_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (cfg_fire),
        .wr_ch       (cfg_ch),
        .wr_ftw      (cfg_ftw),
        .wr_chen     (cfg_en),
        .adv         (issue),
        .ptr         (ptr),
        .any_en      (any_en),
        .first_ch    (first_ch),
        .first_phase (first_phase),
        .next_vld    (next_vld),
        .next_ch     (next_ch),
        .next_phase  (next_phase)
    );

    // The pipe contents after the next shift carry no issue: the last result
    // is being captured now, so the sweep can end.
    assign pipe_after = pipe_vld << 1;
    assign drain_done = (pipe_after == '0);

    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        issue            = 1'b0;
        load_phase       = 1'b0;
        phase_from_first = 1'b0;
        case (state)
            IDLE: begin
                if (tick && any_en) begin
                    state_nxt        = ISSUE;
                    ptr_nxt          = first_ch;
                    load_phase       = 1'b1;
                    phase_from_first = 1'b1;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (next_vld) begin
                    ptr_nxt    = next_ch;
                    load_phase = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cfg_rdy_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cfg_rdy_q <= (state_nxt == IDLE);
        end
    end

    // lut_phase is loaded on the edge that enters each issue cycle, so the LUT
    // sees the pre-increment phase throughout that cycle; it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_phase <= '0;
        end else if (load_phase) begin
            lut_phase <= phase_from_first ? first_phase : next_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int k = 0; k < LUT_LAT; k++) begin
                pipe_ch[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_ch[0]  <= ptr;
            for (int k = 1; k < LUT_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_ch[k]  <= pipe_ch[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else begin
            out_valid <= pipe_vld[LUT_LAT-1];
            if (pipe_vld[LUT_LAT-1]) begin
                out_ch     <= pipe_ch[LUT_LAT-1];
                out_sample <= lut_sample;
            end
        end
    end

    // Set wins over clear so a coincident overrun is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (tick && busy) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sine_channel_scheduler.md
Name: sine_channel_scheduler

Overview:
- Time-multiplexes one shared `sine_lookup` instance across NUM_CH independent DDS channels.
- Each channel owns a phase accumulator and a frequency tuning word (FTW).
- On every sample-rate `tick` the block sweeps the enabled channels in ascending index order. Per channel it issues the phase to the LUT and advances the accumulator.
- It returns each LUT result tagged with its channel id. It sits between the TT I/O/config logic and `sine_lookup`.

Parameters:
- NUM_CH, 4, number of channels (power of two, 2..8).
- PHASE_W, 16, accumulator/FTW width (>= 8).
- LUT_LAT, 1, cycles from `lut_phase` to valid `lut_sample` (>= 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-cycle sample-rate strobe
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_ftw  in  PHASE_W  new tuning word
- cfg_en  in  1  new channel enable
- ovr_clr  in  1  clears the overrun flag
- lut_phase  out  8  phase to sine_lookup, equal to acc[PHASE_W-1 -: 8]
- lut_sample  in  8  sample from sine_lookup
- out_valid  out  1  out_sample/out_ch valid this cycle
- out_ch  out  $clog2(NUM_CH)  channel of out_sample
- out_sample  out  8  sine sample
- busy  out  1  sweep in progress
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - all acc, ftw and en cleared to 0
  - state=IDLE
  - lut_phase=0, out_valid=0, out_ch=0, out_sample=0, overrun=0, busy=0
  - cfg_ready=0 during reset
  - reset mid-sweep aborts the sweep; in-flight samples are discarded and never reported.
- States IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - cfg_ready=1.
  - On tick: if any en=1, go to ISSUE with ptr = lowest enabled channel. If none are enabled, stay IDLE and produce no outputs.
  - If cfg handshake and tick occur in the same cycle, the config write lands first; the sweep uses the new ftw/en.
- ISSUE:
  - One enabled channel per cycle; disabled channels are skipped at zero cost.
  - In issue cycle i: lut_phase = acc[ptr][PHASE_W-1 -: 8] (pre-increment value, registered).
  - acc[ptr] <= acc[ptr] + ftw[ptr] mod 2^PHASE_W (wraps silently).
  - After the highest enabled channel, go to DRAIN.
- DRAIN: wait until all LUT_LAT in-flight results have emerged, then go to IDLE.
- Result timing:
  - A channel-id/valid shift register of depth LUT_LAT tracks issues.
  - lut_sample is captured in cycle i+LUT_LAT.
  - out_valid/out_ch/out_sample are presented in cycle i+LUT_LAT+1 for exactly one cycle.
- Tick-to-first-issue latency: 1 cycle. Tick-to-first-out_valid: LUT_LAT+2 cycles.
- busy=1 in ISSUE and DRAIN. cfg_ready=0 while busy, so config never changes mid-sweep.
- Config write:
  - sets ftw[cfg_ch]=cfg_ftw and en[cfg_ch]=cfg_en.
  - cfg_en=0 also clears acc[cfg_ch] to 0.
  - Re-writing an enabled channel with cfg_en=1 keeps acc (phase-continuous FTW change).
- Overrun:
  - tick while busy sets overrun and is otherwise ignored (no queued sweep).
  - ovr_clr clears it. Simultaneous set and clr leaves overrun=1.
- lut_phase holds its last value outside ISSUE.

Decomposition:
- Package `sine_sched_pkg`:
  - state enum `sched_state_t` {IDLE, ISSUE, DRAIN}
  - default NUM_CH/PHASE_W constants
  - channel-id width function
- Sub-module `phase_acc_bank`:
  - per-channel ftw/en/acc register file
  - one write port (config) and one read/accumulate port (ptr)
  - priority-encoder output "next enabled channel above ptr"
- The top-level FSM, issue/return pipeline and overrun live in sine_channel_scheduler.

Test Plan:
- Stub LUT: sample = phase ^ 0x80, LUT_LAT=1.
- ch0 en, ftw=0x0100; 4 ticks 20 cycles apart -> lut_phase 0x00,0x01,0x02,0x03; out_sample 0x80,0x81,0x82,0x83; out_ch=0; each out_valid exactly 3 cycles after its tick.
- ch0 ftw=0xFFFF -> acc 0x0000,0xFFFF,0xFFFE; lut_phase 0x00,0xFF,0xFF (wrap check).
- ch1 and ch3 enabled (ftw 0x0200, 0x0400), ch0/ch2 disabled; 2 ticks -> per sweep 2 consecutive issue cycles, out_ch sequence 1,3,1,3, out_sample 0x80,0x80,0x82,0x84, busy high for 3 cycles per sweep.
- Tick asserted while busy -> overrun=1 and no extra outputs; ovr_clr -> overrun=0; ovr_clr together with a second overrun tick -> overrun stays 1.
- Disable ch0 via cfg_en=0 after 5 ticks, then re-enable -> first lut_phase 0x00. Re-write an enabled channel's FTW with cfg_en=1 -> phase continues from the old acc.
- Assert rst_n=0 mid-ISSUE -> all outputs 0 immediately, no out_valid after release; cfg_ready=1 once reset is released.
- All channels disabled; tick -> busy stays 0, no out_valid.
